// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode and FSM state encodings shared by seq_alu and its
// iterative multiplier. Multiplier build option: SEQ_ALU_MUL_EN.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND     = 4'h0,
    OP_OR      = 4'h1,
    OP_NOT     = 4'h2,
    OP_NOR     = 4'h3,
    OP_XOR     = 4'h4,
    OP_NAND    = 4'h5,
    OP_ADD     = 4'h6,
    OP_SUB     = 4'h7,
    OP_ABSDIFF = 4'h8,
    OP_MUL     = 4'h9,
    OP_LSL1    = 4'hA,
    OP_ASL1    = 4'hB,
    OP_LSR1    = 4'hC,
    OP_ASR1    = 4'hD,
    OP_ILL_E   = 4'hE,
    OP_ILL_F   = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One multiplier bit is consumed per cycle, half the datapath width.
  function automatic int unsigned mul_iters(input int unsigned width);
    return width / 2;
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned MUL_ITERS     = mul_iters(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_alu_mul.sv
// seq_alu_mul: iterative shift-add multiplier, low halves of the operands,
// full-width product. Used by seq_alu only when SEQ_ALU_MUL_EN is defined.
import seq_alu_pkg::*;

module seq_alu_mul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WIDTH/2-1:0]     a,
  input  logic [WIDTH/2-1:0]     b,
  output logic                   done,
  output logic [WIDTH-1:0]       product
);

  localparam int unsigned HALF = mul_iters(WIDTH);
  localparam int unsigned CW   = $clog2(HALF + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [HALF-1:0]  mplier;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc_next;

  // Partial-product add for the current multiplier bit.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  // done flags the final iteration; product is that iteration's sum so the
  // consumer can register it on the same edge.
  assign done    = (count == CW'(1));
  assign product = acc_next;

  // Load on start, then shift/accumulate until the counter drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{(WIDTH-HALF){1'b0}}, a};
      mplier <= b;
      count  <= CW'(HALF);
    end else if (count != '0) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered result and flags, one operation in
// flight. Define SEQ_ALU_MUL_EN to build the iterative multiplier (opcode 9);
// otherwise opcode 9 is illegal and every op completes in one cycle.
import seq_alu_pkg::*;

module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t     state, state_next;
  opcode_t    opcode;
  logic       accept;
  logic       is_mul;
  logic       mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [WIDTH:0]   sum, dif;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] r_y;
  logic             r_c, r_n, r_z, r_v, r_il;

  assign opcode    = opcode_t'(op);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  assign is_mul = (opcode == OP_MUL);

  seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a[WIDTH/2-1:0]),
    .b       (b[WIDTH/2-1:0]),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  // Shared adders: SUB and ABSDIFF both use a + ~b + 1.
  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign dif     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);

  // Single-cycle result and flags, registered on accept.
  always_comb begin
    r_y  = '0;
    r_c  = 1'b0;
    r_v  = 1'b0;
    r_il = 1'b0;
    case (opcode)
      OP_AND:     r_y = a & b;
      OP_OR:      r_y = a | b;
      OP_NOT:     r_y = ~a;
      OP_NOR:     r_y = ~(a | b);
      OP_XOR:     r_y = a ^ b;
      OP_NAND:    r_y = ~(a & b);
      OP_ADD: begin
        r_y = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = add_ovf;
      end
      OP_SUB: begin
        r_y = dif[WIDTH-1:0];
        r_c = dif[WIDTH];
        r_v = sub_ovf;
      end
      OP_ABSDIFF: begin
        r_y = dif[WIDTH-1] ? (~dif[WIDTH-1:0] + ONE) : dif[WIDTH-1:0];
        r_v = sub_ovf;
      end
      OP_LSL1: begin
        r_y = {a[WIDTH-2:0], 1'b0};
        r_c = a[WIDTH-1];
      end
      OP_ASL1: begin
        r_y = {a[WIDTH-2:0], 1'b0};
        r_c = a[WIDTH-1];
        r_v = a[WIDTH-1] ^ a[WIDTH-2];
      end
      OP_LSR1: begin
        r_y = {1'b0, a[WIDTH-1:1]};
        r_c = a[0];
      end
      OP_ASR1: begin
        r_y = {a[WIDTH-1], a[WIDTH-1:1]};
        r_c = a[0];
      end
      default:    r_il = 1'b1;
    endcase
    r_n = (opcode == OP_ABSDIFF || r_il) ? 1'b0 : r_y[WIDTH-1];
    r_z = (r_y == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; DONE never accepts, even during the output handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = is_mul ? BUSY : DONE;
`ifdef SEQ_ALU_MUL_EN
      BUSY: if (mul_done) state_next = DONE;
`endif
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result/flag registers change only when entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      cout     <= 1'b0;
      negative <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !is_mul) begin
      y        <= r_y;
      cout     <= r_c;
      negative <= r_n;
      zero     <= r_z;
      overflow <= r_v;
      illegal  <= r_il;
    end else if (state == BUSY && mul_done) begin
      y        <= mul_product;
      cout     <= 1'b0;
      negative <= mul_product[WIDTH-1];
      zero     <= (mul_product == '0);
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32. Expected results come
// from an integer-arithmetic reference model and are queued at issue time.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  op;
  logic [31:0] a, b, y;
  logic        cin;
  logic        out_valid, out_ready;
  logic        cout, negative, zero, overflow, illegal;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] y;
    logic        c, n, z, v, il;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] last_y;
  logic        last_c, last_n, last_z, last_v, last_il;

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .cout      (cout),
    .negative  (negative),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic ovf32(input longint s);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Reference model using wide signed arithmetic for carries and overflow.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x,
                                 input logic [31:0] w, input logic ci);
    exp_t e;
    longint sx, sw;
    logic [63:0] full;
    logic [31:0] d;
    sx = longint'($signed(x));
    sw = longint'($signed(w));
    e.y = 0; e.c = 0; e.v = 0; e.il = 0; e.lat = 1;
    case (o)
      4'h0: e.y = x & w;
      4'h1: e.y = x | w;
      4'h2: e.y = ~x;
      4'h3: e.y = ~(x | w);
      4'h4: e.y = x ^ w;
      4'h5: e.y = ~(x & w);
      4'h6: begin
        full = {32'd0, x} + {32'd0, w} + {63'd0, ci};
        e.y = full[31:0]; e.c = full[32];
        e.v = ovf32(sx + sw + longint'(ci));
      end
      4'h7: begin
        e.y = x - w; e.c = (x >= w); e.v = ovf32(sx - sw);
      end
      4'h8: begin
        d = x - w;
        e.y = d[31] ? (32'd0 - d) : d;
        e.v = ovf32(sx - sw);
      end
`ifdef SEQ_ALU_MUL_EN
      4'h9: begin
        e.y = {16'd0, x[15:0]} * {16'd0, w[15:0]};
        e.lat = 16;
      end
`endif
      4'hA: begin e.y = x << 1; e.c = x[31]; end
      4'hB: begin e.y = x << 1; e.c = x[31]; e.v = x[31] ^ x[30]; end
      4'hC: begin e.y = x >> 1; e.c = x[0]; end
      4'hD: begin e.y = 32'($signed(x) >>> 1); e.c = x[0]; end
      default: e.il = 1;
    endcase
    e.n = (o == 4'h8 || e.il) ? 1'b0 : e.y[31];
    e.z = (e.y == 0);
    return e;
  endfunction

  // Issue one op at a negedge, wait for the result, compare against the
  // scoreboard, hold out_ready low for 'hold' cycles, then hand it off.
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] w,
                       input logic ci, input int hold);
    exp_t e;
    int lat;
    logic [31:0] y0;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; op = o; a = x; b = w; cin = ci;
    exp_q.push_back(model(o, x, w, ci));
    @(negedge clk);
    in_valid = 0; op = 4'($urandom); a = $urandom; b = $urandom; cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("in_ready_busy", in_ready, 0);
      in_valid = (lat % 3 == 0);
      @(negedge clk);
      lat++;
    end
    in_valid = 0;
    check("out_valid", out_valid, 1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("latency", lat, e.lat);
    check("y", y, e.y);
    check("cout", cout, e.c);
    check("negative", negative, e.n);
    check("zero", zero, e.z);
    check("overflow", overflow, e.v);
    check("illegal", illegal, e.il);
    last_y = y; last_c = cout; last_n = negative;
    last_z = zero; last_v = overflow; last_il = illegal;
    y0 = y;
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom;
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
      check("hold_y", y, y0);
      check("hold_cout", cout, last_c);
    end
    // Handshake cycle also offers a new op, which DONE must not take.
    out_ready = 1; in_valid = 1; op = 4'h6; a = 32'd1; b = 32'd1;
    @(negedge clk);
    out_ready = 0; in_valid = 0;
    check("post_hs_valid", out_valid, 0);
    check("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 0; op = 0; a = 0; b = 0; cin = 0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_flags", {cout, negative, zero, overflow, illegal}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_ready", in_ready, 1);

    // ADD signed overflow
    do_op(4'h6, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
    check("add_y", last_y, 32'h80000000);
    check("add_flags", {last_v, last_n, last_c, last_z}, 4'b1100);

    // SUB and ABSDIFF 5,7
    do_op(4'h7, 32'd5, 32'd7, 1'b1, 0);
    check("sub_y", last_y, 32'hFFFFFFFE);
    check("sub_nc", {last_n, last_c}, 2'b10);
    do_op(4'h8, 32'd5, 32'd7, 1'b0, 0);
    check("absdiff_y", last_y, 32'd2);
    check("absdiff_n", last_n, 0);
    do_op(4'h8, 32'h80000000, 32'h00000000, 1'b0, 0);
    check("absdiff_wrap", last_y, 32'h80000000);

    // Backpressure on LSR1
    do_op(4'hC, 32'h00000003, 32'h0, 1'b0, 5);
    check("lsr1_y", last_y, 32'h00000001);
    check("lsr1_c", last_c, 1);

    // Illegal opcodes; opcode 9 without the multiplier
    do_op(4'hE, 32'h12345678, 32'h9ABCDEF0, 1'b1, 0);
    check("ille", {last_y, last_il, last_z}, {32'd0, 2'b11});
    do_op(4'hF, 32'hFFFFFFFF, 32'h1, 1'b0, 1);
`ifdef SEQ_ALU_MUL_EN
    do_op(4'h9, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 0);
    check("mul_y", last_y, 32'hFFFE0001);
    do_op(4'h9, 32'hABCD0003, 32'h12340005, 1'b0, 2);
    // Reset during iteration 8 of a multiply
    in_valid = 1; op = 4'h9; a = 32'h0000FFFF; b = 32'h0000FFFF;
    @(negedge clk);
    in_valid = 0;
    repeat (7) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("mulrst_valid", out_valid, 0);
    check("mulrst_y", y, 0);
    check("mulrst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
`else
    do_op(4'h9, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 0);
    check("op9_illegal", last_il, 1);
`endif

    // Reset while a result is waiting in DONE
    in_valid = 1; op = 4'h1; a = 32'hF0F0F0F0; b = 32'h0F0F0F0F;
    @(negedge clk);
    in_valid = 0;
    check("pre_rst_valid", out_valid, 1);
    #2 rst_n = 0;
    #1;
    check("donerst_valid", out_valid, 0);
    check("donerst_y", y, 0);
    check("donerst_n", negative, 0);
    check("donerst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_op(4'h6, 32'd2, 32'd3, 1'b0, 0);
    check("add_after_rst", last_y, 32'd5);

    // Shift and carry-in corners
    do_op(4'hB, 32'h40000001, 32'h0, 1'b0, 0);
    do_op(4'hA, 32'h80000000, 32'h0, 1'b0, 0);
    do_op(4'hD, 32'h80000001, 32'h0, 1'b0, 0);
    do_op(4'h6, 32'hFFFFFFFF, 32'h00000000, 1'b1, 0);
    do_op(4'h7, 32'h80000000, 32'h00000001, 1'b0, 0);

    // Random mix
    for (int i = 0; i < 40; i++)
      do_op(4'($urandom), $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)));

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the lab's combinational 32-bit ALU. It has full-width bitwise ops, add/sub/abs-diff, shifts and a multi-cycle iterative multiplier. Results and flags are registered behind a valid/ready handshake. It sits between an operand-issue stage and a writeback stage, one operation in flight at a time.

## Interface
Parameters:
- WIDTH, 32, datapath width; even, ≥ 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low.**
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; equals (state == IDLE).
- op  in  4  opcode, encoding below.
- a, b  in  WIDTH  operands.
- cin  in  1  carry-in, ADD only.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- y  out  WIDTH  result.
- cout, negative, zero, overflow  out  1  flags.
- illegal  out  1  opcode was not executable.

## Operation
- Opcodes:
  - 0 AND, 1 OR, 2 NOT a, 3 NOR, 4 XOR, 5 NAND: all bitwise, full width.
  - 6 ADD a+b+cin.
  - 7 SUB a−b.
  - 8 ABSDIFF |a−b| (signed difference).
  - 9 MUL: unsigned a[W/2−1:0]·b[W/2−1:0], full WIDTH product.
  - A LSL1, B ASL1, C LSR1, D ASR1.
  - E, F illegal.
- Accept on a rising edge with in_valid && in_ready. op/a/b/cin are captured then; later input changes are ignored.
- FSM:
  - IDLE: on accept, go to DONE (non-MUL) or BUSY (MUL).
  - BUSY: go to DONE when the iteration counter expires.
  - DONE: hold; go to IDLE on out_valid && out_ready.
- No accept occurs in DONE, even when out_ready is high in the same cycle.
- Flags:
  - Default for every op: negative = y[W−1], zero = (y == 0), cout = 0, overflow = 0, illegal = 0.
  - ADD: cout = carry out of bit W−1. overflow = signed overflow (operands same sign, result sign differs).
  - SUB: computed as a + ~b + 1. cout = no-borrow (a ≥ b unsigned). overflow = signed overflow of the subtraction. cin is ignored.
  - ABSDIFF:
    - y = (a−b) if bit W−1 of a−b is 0, otherwise −(a−b).
    - negative = 0.
    - overflow = signed overflow of a−b.
    - Most-negative magnitude wraps unchanged.
  - LSL1: y = a<<1, cout = a[W−1].
  - ASL1: as LSL1, plus overflow = a[W−1]^a[W−2].
  - LSR1: y = a>>1 with zero fill, cout = a[0].
  - ASR1: y = a>>1 with sign fill, cout = a[0].
  - Illegal (E, F, or 9 when MUL is compiled out): y = 0, illegal = 1, zero = 1, other flags 0. Completes with single-cycle timing.
- MUL is shift-add: one multiplier bit per cycle, W/2 iterations, with a WIDTH-bit accumulator. Arithmetic is modulo 2^WIDTH; this op cannot overflow.

## Timing
- Reset values:
  - state IDLE, so in_ready = 1 during and after reset.
  - out_valid = 0.
  - y = 0; cout, negative, zero, overflow, illegal = 0.
  - Iteration counter = 0, accumulator = 0.
- Non-MUL latency: accept on edge k → out_valid = 1 after edge k+1 is not used; out_valid is high after edge k itself. In other words, out_valid is visible in the first cycle following the accept.
- MUL latency: accept on edge k → BUSY for W/2 cycles → out_valid high after edge k+W/2 (16 cycles for WIDTH=32).
- y and all flags are stable for the whole time out_valid is high. They may change only on entering DONE.
- After the handshake edge: out_valid = 0 and in_ready = 1. Peak throughput is therefore one op per 2 cycles.
- in_valid while in BUSY or DONE is ignored and not queued.
- Reset asserted mid-MUL or in DONE aborts the operation: no result is produced, and all outputs take their reset values immediately (asynchronously).

## Configuration
- SEQ_ALU_MUL_EN defined: MUL is implemented as above, including the multiplier sub-module and BUSY state.
- SEQ_ALU_MUL_EN undefined:
  - No multiplier hardware and no BUSY state.
  - Opcode 9 is treated as illegal.
  - Every op has single-cycle latency.

## Structure
- Package seq_alu_pkg contains:
  - Opcode enum, 4 bits, values 0x0–0xF as above.
  - FSM state enum: IDLE, BUSY, DONE.
  - Localparam for the MUL iteration count, W/2.
- Sub-module seq_alu_mul: iterative shift-add multiplier.
  - Ports: start, operands, done, product.
  - Instantiated only under SEQ_ALU_MUL_EN.
- Flag and result logic for the non-MUL ops lives in the top level.

## Test plan
All scenarios use WIDTH=32.
- ADD a=0x7FFFFFFF, b=0x00000001, cin=0 → y=0x80000000, overflow=1, negative=1, cout=0, zero=0; out_valid in the cycle after accept.
- SUB a=5, b=7 → y=0xFFFFFFFE, negative=1, cout=0. ABSDIFF a=5, b=7 → y=2, negative=0.
- MUL a=0x0000FFFF, b=0x0000FFFF → y=0xFFFE0001, out_valid exactly 16 cycles after accept. in_ready=0 throughout, and in_valid pulses during BUSY are ignored.
- Backpressure: LSR1 a=0x00000003 with out_ready held low 5 cycles → y=0x00000001 and cout=1 stable, in_ready=0. On the handshake edge, in_ready=1 next cycle.
- Reset pulse during MUL iteration 8 → out_valid=0, y=0, in_ready=1 immediately. A following ADD 2+3 yields y=5.
- op=0xE → y=0, illegal=1, zero=1. With SEQ_ALU_MUL_EN undefined, op=9 → illegal=1 with single-cycle latency.
